// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Multiplies and HI/LO moves complete in one cycle; divides take 32 restoring
// iterations plus one sign-fixup cycle, signalled with busy/done.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StDiv, StFix} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  hi_q, lo_q;
  logic              done_q;
  logic [WIDTH-1:0]  rem_q, quo_q, dvs_q, a_raw_q;
  logic              q_neg_q, r_neg_q, div_zero_q;

  logic              accept;
  logic              is_signed_div;
  logic              a_neg, b_neg;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH:0]    shifted;
  logic              fits;
  logic [WIDTH-1:0]  rem_nxt, quo_nxt;
  logic [WIDTH-1:0]  q_fix, r_fix;

  assign accept = start_i && !busy_o && !flush_i;

  // Operand preparation: sign-extended product and divide magnitudes
  always_comb begin
    a_ext = {{WIDTH{1'b0}}, a_i};
    b_ext = {{WIDTH{1'b0}}, b_i};
    if (op_i == OpMult) begin
      a_ext = {{WIDTH{a_i[WIDTH-1]}}, a_i};
      b_ext = {{WIDTH{b_i[WIDTH-1]}}, b_i};
    end
    prod = a_ext * b_ext;

    is_signed_div = (op_i == OpDiv);
    a_neg = is_signed_div && a_i[WIDTH-1];
    b_neg = is_signed_div && b_i[WIDTH-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
  end

  // One restoring iteration: shift in the next dividend bit, subtract if it fits
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    // When it fits the difference is below the divisor, so the low bits suffice
    rem_nxt = fits ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], fits};
    q_fix   = q_neg_q ? -quo_q : quo_q;
    r_fix   = r_neg_q ? -rem_q : rem_q;
  end

  // Control FSM and HI/LO datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      a_raw_q    <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            case (op_i)
              OpMult, OpMultu: begin
                hi_q   <= prod[2*WIDTH-1:WIDTH];
                lo_q   <= prod[WIDTH-1:0];
                done_q <= 1'b1;
              end
              OpMthi: begin
                hi_q   <= a_i;
                done_q <= 1'b1;
              end
              OpMtlo: begin
                lo_q   <= a_i;
                done_q <= 1'b1;
              end
              OpDiv, OpDivu: begin
                rem_q      <= '0;
                quo_q      <= a_mag;
                dvs_q      <= b_mag;
                a_raw_q    <= a_i;
                q_neg_q    <= a_neg ^ b_neg;
                r_neg_q    <= a_neg;
                div_zero_q <= (b_i == '0);
                cnt_q      <= '0;
                state_q    <= StDiv;
              end
              default: ;  // reserved ops are dropped silently
            endcase
          end
        end
        StDiv: begin
          if (flush_i) begin
            state_q <= StIdle;
          end else begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntLast) state_q <= StFix;
          end
        end
        StFix: begin
          state_q <= StIdle;
          if (!flush_i) begin
            done_q <= 1'b1;
            if (div_zero_q) begin
              // Divide by zero reports the raw dividend, not the magnitude
              lo_q <= '1;
              hi_q <= a_raw_q;
            end else begin
              lo_q <= q_fix;
              hi_q <= r_fix;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: multiplies, moves, divides, flush and reset.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        flush_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int errs;
  int checks;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for a single cycle; returns sampled in cycle N+1
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    step();
    start_i = 1'b0;
  endtask

  // Full divide: busy over N+1..N+33, result and done in N+34
  task automatic run_div(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int inject_at);
    int bad;
    bad = 0;
    issue(op, a, b);
    for (int k = 1; k <= 33; k++) begin
      if (!busy_o || done_o) bad++;
      if (k == inject_at) begin
        start_i = 1'b1;
        op_i    = 3'd1;
        a_i     = 32'd3;
        b_i     = 32'd3;
      end
      step();
      start_i = 1'b0;
    end
    check_eq({tag, " busy window"}, bad, 0);
    check_eq({tag, " done"}, done_o, 1);
    check_eq({tag, " busy end"}, busy_o, 0);
    check_eq({tag, " lo"}, lo_o, exp_lo);
    check_eq({tag, " hi"}, hi_o, exp_hi);
    step();
    check_eq({tag, " done pulse"}, done_o, 0);
  endtask

  initial begin
    errs    = 0;
    checks  = 0;
    reset   = 1'b1;
    start_i = 1'b0;
    op_i    = 3'd0;
    a_i     = '0;
    b_i     = '0;
    flush_i = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_eq("rst busy", busy_o, 0);
    check_eq("rst done", done_o, 0);
    check_eq("rst hi", hi_o, 0);
    check_eq("rst lo", lo_o, 0);

    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    check_eq("mult done", done_o, 1);
    check_eq("mult busy", busy_o, 0);
    check_eq("mult hi", hi_o, 32'hFFFF_FFFF);
    check_eq("mult lo", lo_o, 32'hFFFF_FFFA);
    step();
    check_eq("mult done pulse", done_o, 0);

    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    check_eq("multu done", done_o, 1);
    check_eq("multu hi", hi_o, 32'h0000_0002);
    check_eq("multu lo", lo_o, 32'hFFFF_FFFA);

    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    check_eq("rsvd done", done_o, 0);
    check_eq("rsvd busy", busy_o, 0);
    check_eq("rsvd hi", hi_o, 32'h0000_0002);
    check_eq("rsvd lo", lo_o, 32'hFFFF_FFFA);

    run_div("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    run_div("divu 7/2", 3'd3, 32'd7, 32'd2, 32'd3, 32'd1, 5);
    run_div("div 7/-2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0);
    run_div("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
    run_div("divu 5/0", 3'd3, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0);
    run_div("div -7/0", 3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 0);

    // Back-to-back single-cycle moves
    start_i = 1'b1;
    op_i    = 3'd4;
    a_i     = 32'h0000_1234;
    step();
    check_eq("mthi done", done_o, 1);
    check_eq("mthi hi", hi_o, 32'h0000_1234);
    op_i = 3'd5;
    a_i  = 32'h0000_5678;
    step();
    start_i = 1'b0;
    check_eq("mtlo done", done_o, 1);
    check_eq("mtlo lo", lo_o, 32'h0000_5678);
    check_eq("mtlo hi kept", hi_o, 32'h0000_1234);

    // Start coincident with flush is dropped
    flush_i = 1'b1;
    issue(3'd2, 32'd100, 32'd7);
    flush_i = 1'b0;
    check_eq("flush+start busy", busy_o, 0);
    check_eq("flush+start done", done_o, 0);

    // Flush mid-divide at N+10
    issue(3'd2, 32'd100, 32'd7);
    for (int k = 0; k < 9; k++) step();
    check_eq("pre-flush busy", busy_o, 1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check_eq("flush busy", busy_o, 0);
    check_eq("flush done", done_o, 0);
    check_eq("flush hi", hi_o, 32'h0000_1234);
    check_eq("flush lo", lo_o, 32'h0000_5678);
    step();
    check_eq("flush no late done", done_o, 0);

    // Flush in the fixup cycle N+33 suppresses the write
    issue(3'd3, 32'd100, 32'd7);
    for (int k = 0; k < 32; k++) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check_eq("fixflush done", done_o, 0);
    check_eq("fixflush busy", busy_o, 0);
    check_eq("fixflush hi", hi_o, 32'h0000_1234);
    check_eq("fixflush lo", lo_o, 32'h0000_5678);

    // Reset mid-divide at N+10
    issue(3'd2, 32'd100, 32'd7);
    for (int k = 0; k < 9; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rstdiv busy", busy_o, 0);
    check_eq("rstdiv done", done_o, 0);
    check_eq("rstdiv hi", hi_o, 0);
    check_eq("rstdiv lo", lo_o, 0);

    // Unit accepts work again after reset
    run_div("divu 100/7", 3'd3, 32'd100, 32'd7, 32'd14, 32'd2, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
